// File: rtl/barrett_final_reduce.sv
// Final stage of the Barrett reduction: forms r = x - q*M one limb per cycle,
// then applies up to two conditional subtractions of M. Optional macro: BARRETT_EARLY_EXIT_EN.
module barrett_final_reduce #(
  parameter int WIDTH = 78,
  parameter int LIMB  = 20
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH+1:0] x_low,
  input  logic [WIDTH-1:0] q,
  input  logic [WIDTH-1:0] modulus,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] r,
  output logic             err
);

  localparam int W     = WIDTH + 2;
  localparam int NLIMB = (WIDTH + LIMB - 1) / LIMB;
  localparam int QW    = NLIMB * LIMB;
  localparam int CW    = (NLIMB > 1) ? $clog2(NLIMB) : 1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_MUL,
    S_SUB,
    S_CORR1,
    S_CORR2,
    S_DONE
  } state_t;

  state_t          state, next_state;
  logic [W-1:0]    x_q, acc, rr;
  logic [WIDTH-1:0] q_q, m_q;
  logic [CW-1:0]   limb_cnt;

  logic [QW-1:0]   q_ext;
  logic [LIMB-1:0] q_limb;
  logic [W-1:0]    pp, pp_sh, m_ext, diff, rr_corr, result_src;
  logic            last_limb, load_result;

  // Only the low W bits of each partial product can reach the truncated sum,
  // so the multiply is done at W bits directly.
  always_comb begin
    q_ext      = QW'(q_q);
    q_limb     = q_ext[LIMB*int'(limb_cnt) +: LIMB];
    pp         = W'(q_limb) * W'(m_q);
    pp_sh      = pp << (LIMB * int'(limb_cnt));
    m_ext      = W'(m_q);
    diff       = x_q - acc;
    rr_corr    = (rr >= m_ext) ? (rr - m_ext) : rr;
    last_limb  = (limb_cnt == CW'(NLIMB - 1));
    result_src = (state == S_SUB) ? diff : rr_corr;
  end

  // NOTE: sequential state is updated with <= only so every register samples
  // the pre-edge values, regardless of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= S_IDLE;
    else     state <= next_state;
  end

  // NOTE: next_state gets a default before the case, so no path can infer a latch.
  always_comb begin
    next_state = state;
    unique case (state)
      S_IDLE:  if (in_valid) next_state = S_MUL;
      S_MUL:   if (last_limb) next_state = S_SUB;
      S_SUB: begin
        next_state = S_CORR1;
`ifdef BARRETT_EARLY_EXIT_EN
        if (diff < m_ext) next_state = S_DONE;
`endif
      end
      S_CORR1: begin
        next_state = S_CORR2;
`ifdef BARRETT_EARLY_EXIT_EN
        if (rr_corr < m_ext) next_state = S_DONE;
`endif
      end
      S_CORR2: next_state = S_DONE;
      S_DONE:  if (out_ready) next_state = S_IDLE;
      default: next_state = S_IDLE;
    endcase
  end

  always_comb begin
    in_ready  = (state == S_IDLE);
    out_valid = (state == S_DONE);
  end

  // Result is captured on whichever edge enters DONE, so early exit and the
  // full path share one err computation.
  assign load_result = (state != S_DONE) && (next_state == S_DONE);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      x_q      <= '0;
      q_q      <= '0;
      m_q      <= '0;
      acc      <= '0;
      rr       <= '0;
      limb_cnt <= '0;
      r        <= '0;
      err      <= 1'b0;
    end else begin
      unique case (state)
        S_IDLE: begin
          if (in_valid) begin
            x_q      <= x_low;
            q_q      <= q;
            m_q      <= modulus;
            acc      <= '0;
            limb_cnt <= '0;
          end
        end
        S_MUL: begin
          acc      <= acc + pp_sh;
          limb_cnt <= limb_cnt + CW'(1);
        end
        S_SUB:            rr <= diff;
        S_CORR1, S_CORR2: rr <= rr_corr;
        default: ;
      endcase
      if (load_result) begin
        r   <= result_src[WIDTH-1:0];
        err <= (result_src >= m_ext);
      end
    end
  end

endmodule

// File: tb/tb_barrett_final_reduce.sv
// Directed, table-driven bench for barrett_final_reduce, with hand-written
// sequences for mid-operation reset and output backpressure.
module tb_barrett_final_reduce;

  localparam int WIDTH = 78;
  localparam int W     = WIDTH + 2;
`ifdef BARRETT_EARLY_EXIT_EN
  localparam int LAT_NC = 5;
  localparam int LAT_1C = 6;
`else
  localparam int LAT_NC = 7;
  localparam int LAT_1C = 7;
`endif

  logic             clk = 1'b0;
  logic             rst;
  logic             in_valid, in_ready;
  logic [W-1:0]     x_low;
  logic [WIDTH-1:0] q, modulus;
  logic             out_valid, out_ready;
  logic [WIDTH-1:0] r;
  logic             err;

  barrett_final_reduce #(.WIDTH(WIDTH), .LIMB(20)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .x_low     (x_low),
    .q         (q),
    .modulus   (modulus),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .r         (r),
    .err       (err)
  );

  always #5 clk = ~clk;

  typedef struct {
    string            name;
    logic [W-1:0]     x;
    logic [WIDTH-1:0] q;
    logic [WIDTH-1:0] m;
    logic [WIDTH-1:0] exp_r;
    logic             exp_err;
    int               exp_lat;
  } vec_t;

  vec_t vecs[6];
  int   n_checks = 0;
  int   n_fail   = 0;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Drives a vector at a negedge, lets the next posedge accept it, then
  // scrambles the inputs so only the latched copies can produce the result.
  task automatic start_op(input vec_t v);
    x_low    = v.x;
    q        = v.q;
    modulus  = v.m;
    in_valid = 1'b1;
    check({v.name, " in_ready before accept"}, 128'(in_ready), 128'(1));
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    x_low    = W'({$urandom(), $urandom(), $urandom()});
    q        = WIDTH'({$urandom(), $urandom(), $urandom()});
    modulus  = WIDTH'({$urandom(), $urandom(), $urandom()});
    check({v.name, " in_ready after accept"}, 128'(in_ready), 128'(0));
  endtask

  // Counts edges after acceptance until out_valid is seen, bounded at 20.
  task automatic wait_result(input string name, output int lat);
    lat = 0;
    while (!out_valid && lat < 20) begin
      @(posedge clk);
      lat++;
      @(negedge clk);
    end
    check({name, " out_valid"}, 128'(out_valid), 128'(1));
  endtask

  task automatic release_out(input string name);
    out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    out_ready = 1'b0;
    check({name, " out_valid after handshake"}, 128'(out_valid), 128'(0));
    check({name, " in_ready after handshake"}, 128'(in_ready), 128'(1));
  endtask

  task automatic run_vec(input vec_t v);
    int lat;
    start_op(v);
    wait_result(v.name, lat);
    check({v.name, " r"}, 128'(r), 128'(v.exp_r));
    check({v.name, " err"}, 128'(err), 128'(v.exp_err));
    check({v.name, " latency"}, 128'(lat), 128'(v.exp_lat));
    release_out(v.name);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, time %0t", $time);
    $fatal(1, "watchdog expired");
  end

  initial begin
    int lat;
    int saw;
    logic [WIDTH-1:0] r_hold;
    logic             err_hold;

    vecs[0] = '{name: "no_corr", x: 80'd5000022, q: 78'd5, m: 78'd1000003,
                exp_r: 78'd7, exp_err: 1'b0, exp_lat: LAT_NC};
    vecs[1] = '{name: "two_corr", x: 80'd5000022, q: 78'd3, m: 78'd1000003,
                exp_r: 78'd7, exp_err: 1'b0, exp_lat: 7};
    vecs[2] = '{name: "bound_violation", x: 80'd41, q: 78'd0, m: 78'd10,
                exp_r: 78'd21, exp_err: 1'b1, exp_lat: 7};
    // (x - (2^154-1)) mod 2^80 = 2^79+1; minus M twice = 2^78-1, still >= M.
    vecs[3] = '{name: "wrap_around", x: 80'h8000_0000_0000_0000_0000,
                q: 78'h1FFF_FFFF_FFFF_FFFF_FFFF, m: 78'h2000_0000_0000_0000_0001,
                exp_r: 78'h3FFF_FFFF_FFFF_FFFF_FFFF, exp_err: 1'b1, exp_lat: 7};
    vecs[4] = '{name: "one_corr", x: 80'd5000022, q: 78'd4, m: 78'd1000003,
                exp_r: 78'd7, exp_err: 1'b0, exp_lat: LAT_1C};
    // q has one bit in every limb; q*(2^77+1) mod 2^80 = q + 2^77.
    vecs[5] = '{name: "all_limbs", x: 80'h2000_1000_0100_0010_0008,
                q: 78'h1000_0100_0010_0001, m: 78'h2000_0000_0000_0000_0001,
                exp_r: 78'd7, exp_err: 1'b0, exp_lat: LAT_NC};

    rst       = 1'b1;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    x_low     = '0;
    q         = '0;
    modulus   = '0;
    #12;
    check("reset in_ready", 128'(in_ready), 128'(1));
    check("reset out_valid", 128'(out_valid), 128'(0));
    check("reset r", 128'(r), 128'(0));
    check("reset err", 128'(err), 128'(0));
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    for (int i = 0; i < 6; i++) run_vec(vecs[i]);

    // Reset during MUL: the operation is dropped and never reports.
    start_op(vecs[2]);
    repeat (3) @(posedge clk);
    #1 rst = 1'b1;
    #1;
    check("midreset out_valid", 128'(out_valid), 128'(0));
    check("midreset in_ready", 128'(in_ready), 128'(1));
    check("midreset r", 128'(r), 128'(0));
    @(negedge clk);
    rst = 1'b0;
    saw = 0;
    repeat (12) begin
      @(negedge clk);
      if (out_valid) saw = 1;
    end
    check("midreset dropped op silent", 128'(saw), 128'(0));
    run_vec(vecs[1]);

    // Backpressure: result must hold while a new operand set waits on in_valid.
    start_op(vecs[0]);
    wait_result("bp_first", lat);
    check("bp_first r", 128'(r), 128'(vecs[0].exp_r));
    check("bp_first err", 128'(err), 128'(vecs[0].exp_err));
    r_hold   = r;
    err_hold = err;
    x_low    = vecs[2].x;
    q        = vecs[2].q;
    modulus  = vecs[2].m;
    in_valid = 1'b1;
    repeat (10) begin
      @(negedge clk);
      check("bp hold r", 128'(r), 128'(vecs[0].exp_r));
      check("bp hold err", 128'(err), 128'(err_hold));
      check("bp hold out_valid", 128'(out_valid), 128'(1));
      check("bp hold in_ready", 128'(in_ready), 128'(0));
    end
    check("bp r unchanged", 128'(r), 128'(r_hold));
    out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    out_ready = 1'b0;
    check("bp handshake out_valid", 128'(out_valid), 128'(0));
    check("bp handshake in_ready", 128'(in_ready), 128'(1));
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    check("bp second accepted", 128'(in_ready), 128'(0));
    wait_result("bp_second", lat);
    check("bp_second r", 128'(r), 128'(vecs[2].exp_r));
    check("bp_second err", 128'(err), 128'(vecs[2].exp_err));
    check("bp_second latency", 128'(lat), 128'(vecs[2].exp_lat));
    release_out("bp_second");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
